// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types used by fetch now and decode later.
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Primary opcode field values (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
    logic               valid;
  } ifid_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/imem_rom.sv
// Word-addressed instruction ROM with combinational read; out-of-range addresses read as NOP.
module imem_rom
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 64
) (
  input  logic [29:0]        word_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               in_range
);

  localparam int AW = $clog2(IMEM_DEPTH);

  // Small demo program at the start; the remaining words are distinct LUI r1, idx.
  function automatic logic [INSTR_W-1:0] init_word(input int idx);
    case (idx)
      0:       return 32'h2001_0005;
      1:       return 32'h0022_1820;
      2:       return 32'hAC03_0004;
      3:       return 32'h8C04_0004;
      default: return {OP_LUI, 5'd0, 5'd1, 16'(idx)};
    endcase
  endfunction

  logic [INSTR_W-1:0] rom [IMEM_DEPTH];

  for (genvar gi = 0; gi < IMEM_DEPTH; gi++) begin : g_rom
    assign rom[gi] = init_word(gi);
  end

  always_comb begin
    in_range = (word_addr < 30'(IMEM_DEPTH));
    instr    = in_range ? rom[word_addr[AW-1:0]] : NOP_INSTR;
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID register, sticky fetch error and fetch counter.
module if_stage
  import mips_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] ifid_out,
  output logic [31:0]        ifid_pc4,
  output logic               ifid_valid,
  output logic               fetch_err,
  output logic [31:0]        fetch_count
);

  logic [31:0]        pc_q, pc_d;
  ifid_t              ifid_q, ifid_d;
  logic               fetch_err_q, fetch_err_d;
  logic [31:0]        fetch_count_q, fetch_count_d;

  logic [INSTR_W-1:0] rom_instr;
  logic               rom_in_range;
  logic [31:0]        pc_plus4;

  imem_rom #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_imem (
    .word_addr (pc_q[31:2]),
    .instr     (rom_instr),
    .in_range  (rom_in_range)
  );

  assign pc_plus4 = pc_q + PC_STEP;

  always_comb begin
    pc_d          = pc_q;
    ifid_d        = ifid_q;
    fetch_err_d   = fetch_err_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      // Redirect wins over stall; ifid_pc4 is intentionally left untouched.
      pc_d         = {redirect_pc[31:2], 2'b00};
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
      if (!is_word_aligned(redirect_pc)) begin
        fetch_err_d = 1'b1;
      end
    end else if (!stall) begin
      pc_d         = pc_plus4;
      ifid_d.instr = rom_instr;
      ifid_d.pc4   = pc_plus4;
      ifid_d.valid = rom_in_range;
      if (rom_in_range) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end else begin
        fetch_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      ifid_q        <= '{instr: NOP_INSTR, pc4: 32'd0, valid: 1'b0};
      fetch_err_q   <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      ifid_q        <= ifid_d;
      fetch_err_q   <= fetch_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc          = pc_q;
  assign ifid_out    = ifid_q.instr;
  assign ifid_pc4    = ifid_q.pc4;
  assign ifid_valid  = ifid_q.valid;
  assign fetch_err   = fetch_err_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed plus randomized checks of if_stage against a behavioural fetch model.
module tb_if_stage;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] pc, ifid_out, ifid_pc4, fetch_count;
  logic        ifid_valid, fetch_err;

  if_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .ifid_out    (ifid_out),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .fetch_err   (fetch_err),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rom_m [DEPTH];
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
    m_valid = 1'b0; m_err = 1'b0; m_count = 32'h0;
  endtask

  // Spec-level fetch rules, applied once per rising edge.
  task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc);
    if (rd) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_instr = 32'h0;
      m_valid = 1'b0;
      if (rpc % 4 != 0) m_err = 1'b1;
    end else if (!st) begin
      if ((m_pc / 4) < DEPTH) begin
        m_instr = rom_m[m_pc / 4];
        m_valid = 1'b1;
        m_count = m_count + 1;
      end else begin
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_err = 1'b1;
      end
      m_pc4 = m_pc + 4;
      m_pc = m_pc + 4;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".pc"}, pc, m_pc);
    chk({ctx, ".ifid_out"}, ifid_out, m_instr);
    chk({ctx, ".ifid_pc4"}, ifid_pc4, m_pc4);
    chk({ctx, ".ifid_valid"}, 32'(ifid_valid), 32'(m_valid));
    chk({ctx, ".fetch_err"}, 32'(fetch_err), 32'(m_err));
    chk({ctx, ".fetch_count"}, fetch_count, m_count);
  endtask

  // Inputs change on the falling edge; outputs are compared on the next falling edge.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input string ctx);
    stall = st; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    model_step(st, rd, rpc);
    @(negedge clk);
    $display("cycle %-8s stall=%0b redir=%0b rpc=%h -> pc=%h ifid=%h v=%0b err=%0b cnt=%0d",
             ctx, st, rd, rpc, pc, ifid_out, ifid_valid, fetch_err, fetch_count);
    check_all(ctx);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string ctx);
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    $display("reset %-8s pc=%h ifid=%h v=%0b err=%0b cnt=%0d", ctx, pc, ifid_out, ifid_valid, fetch_err, fetch_count);
    check_all({ctx, ".async"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] rpc_r;
  int          r;

  initial begin
    rom_m[0] = 32'h2001_0005;
    rom_m[1] = 32'h0022_1820;
    rom_m[2] = 32'hAC03_0004;
    rom_m[3] = 32'h8C04_0004;
    for (int i = 4; i < DEPTH; i++) rom_m[i] = 32'h3C01_0000 + 32'(i);
    model_reset();

    // Let the design run a little so the first reset pulse clears real state.
    repeat (3) @(posedge clk);
    async_reset("rst0");

    // Sequential fetch of the demo program.
    cycle(0, 0, 0, "seq0");
    chk("seq0.lit_instr", ifid_out, 32'h2001_0005);
    chk("seq0.lit_pc", pc, 32'd4);
    chk("seq0.lit_pc4", ifid_pc4, 32'd4);
    cycle(0, 0, 0, "seq1");
    cycle(0, 0, 0, "seq2");
    cycle(0, 0, 0, "seq3");
    chk("seq3.lit_instr", ifid_out, 32'h8C04_0004);
    chk("seq3.lit_pc", pc, 32'd16);
    chk("seq3.lit_count", fetch_count, 32'd4);

    // Stall with pc=8.
    async_reset("rst1");
    cycle(0, 0, 0, "pre0");
    cycle(0, 0, 0, "pre1");
    cycle(1, 0, 0, "stall0");
    cycle(1, 0, 0, "stall1");
    chk("stall.lit_pc", pc, 32'd8);
    chk("stall.lit_instr", ifid_out, 32'h0022_1820);
    chk("stall.lit_count", fetch_count, 32'd2);
    cycle(0, 0, 0, "unstall");
    chk("unstall.lit_instr", ifid_out, 32'hAC03_0004);

    // Redirect overriding stall.
    cycle(1, 1, 32'h20, "rdst");
    chk("rdst.lit_pc", pc, 32'h20);
    chk("rdst.lit_valid", 32'(ifid_valid), 32'd0);
    cycle(0, 0, 0, "rdnext");
    chk("rdnext.lit_instr", ifid_out, 32'h3C01_0008);

    // Misaligned redirect into out-of-range space.
    cycle(0, 1, 32'h102, "mis");
    chk("mis.lit_pc", pc, 32'h100);
    chk("mis.lit_err", 32'(fetch_err), 32'd1);
    cycle(0, 0, 0, "oor");
    chk("oor.lit_instr", ifid_out, 32'h0);
    chk("oor.lit_count", fetch_count, 32'd4);

    // Wrap: fetch at the top of the address space.
    cycle(0, 1, 32'hFFFF_FFFC, "wrap0");
    cycle(0, 0, 0, "wrap1");
    chk("wrap.lit_pc", pc, 32'h0);

    // Reset while the error flag is set.
    async_reset("rst2");
    cycle(0, 0, 0, "resume");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset("rst_rand");
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 9))
        0:       rpc_r = $urandom();
        1:       rpc_r = 32'(DEPTH * 4 - 4);
        2:       rpc_r = ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
        default: rpc_r = $urandom_range(0, DEPTH - 1) * 4;
      endcase
      if (r < 8)
        cycle(r[0], 1, rpc_r, "rnd");
      else if (r < 30 && (m_pc / 4) < DEPTH)
        cycle(1, 0, rpc_r, "rnd");
      else
        cycle(0, 0, rpc_r, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
